// File: rtl/disp_scheduler.sv
// Round-robin owner of the 8-digit display, switched only at frame boundaries; Gnt updates 1 Clk after the boundary Tick, outputs are registered on Tick.
// Requesters are never stalled, only deferred to the next boundary. Optional LEADING_ZERO_BLANK_EN darkens digits above the top nonzero nibble.
module disp_scheduler #(
   parameter int NREQ        = 4,
   parameter int HOLD_FRAMES = 2
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 Tick,
   input  logic [NREQ-1:0]      Req,
   input  logic [NREQ*32-1:0]   Data,
   output logic [NREQ-1:0]      Gnt,
   output logic [3:0]           Nibble,
   output logic                 Blank,
   output logic [7:0]           LEDSEL,
   output logic                 Frame_done
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int HW = $clog2(HOLD_FRAMES + 1);
   localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_FRAMES - 1);
   localparam logic [IW-1:0] LAST_RST    = IW'(NREQ - 1);

   logic [2:0]      idx_q;
   logic [31:0]     snap_q, snap_d;
   logic [NREQ-1:0] owner_q, owner_d;
   logic [IW-1:0]   last_q, last_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [7:0]      ledsel_q;
   logic [3:0]      nibble_q;
   logic            blank_q, blank_d;
   logic            fd_q;

   logic [IW-1:0]   owner_idx, base_idx, win_idx, sel_idx;
   logic            win_vld, others, keep;
   int              j;

   always_comb begin
      owner_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (owner_q[i]) owner_idx = IW'(i);
      end
      others   = |(Req & ~owner_q);
      keep     = (owner_q != '0) && (|(Req & owner_q)) && ((hold_q != '0) || !others);
      base_idx = (owner_q != '0) ? owner_idx : last_q;

      // circular search starting just after the previous owner
      win_vld = 1'b0;
      win_idx = '0;
      j       = 0;
      for (int i = 1; i <= NREQ; i++) begin
         j = (int'(base_idx) + i) % NREQ;
         if (!win_vld && Req[IW'(j)]) begin
            win_vld = 1'b1;
            win_idx = IW'(j);
         end
      end

      sel_idx = keep ? owner_idx : win_idx;
      owner_d = owner_q;
      last_d  = last_q;
      hold_d  = hold_q;
      snap_d  = snap_q;
      if (keep) begin
         if (!others)              hold_d = HOLD_RELOAD;
         else if (hold_q != '0)    hold_d = hold_q - HW'(1);
         snap_d = Data[32*sel_idx +: 32];
      end else if (win_vld) begin
         owner_d = NREQ'(1) << win_idx;
         last_d  = win_idx;
         hold_d  = HOLD_RELOAD;
         snap_d  = Data[32*sel_idx +: 32];
      end else begin
         owner_d = '0;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [2:0] msd;
   always_comb begin
      msd = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (snap_q[4*k +: 4] != 4'd0) msd = 3'(k);
      end
      blank_d = (owner_q == '0) || (idx_q > msd);
   end
`else
   always_comb begin
      blank_d = (owner_q == '0);
   end
`endif

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         idx_q    <= 3'd0;
         snap_q   <= '0;
         owner_q  <= '0;
         last_q   <= LAST_RST;
         hold_q   <= '0;
         ledsel_q <= 8'hFF;
         nibble_q <= 4'd0;
         blank_q  <= 1'b1;
         fd_q     <= 1'b0;
      end else begin
         fd_q <= 1'b0;
         if (Tick) begin
            ledsel_q <= ~(8'd1 << idx_q);
            nibble_q <= snap_q[{idx_q, 2'b00} +: 4];
            blank_q  <= blank_d;
            idx_q    <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
               owner_q <= owner_d;
               last_q  <= last_d;
               hold_q  <= hold_d;
               snap_q  <= snap_d;
               fd_q    <= 1'b1;
            end
         end
      end
   end

   assign Gnt        = owner_q;
   assign Nibble     = nibble_q;
   assign Blank      = blank_q;
   assign LEDSEL     = ledsel_q;
   assign Frame_done = fd_q;

endmodule

// File: tb/tb_disp_scheduler.sv
// Bench for disp_scheduler: directed scenarios plus randomized traffic against a frame-level model.
module tb_disp_scheduler;
   localparam int NREQ = 4;
   localparam int HOLD = 2;

   logic              Clk = 1'b0;
   logic              Rst_n = 1'b0;
   logic              Tick = 1'b0;
   logic [NREQ-1:0]   Req = '0;
   logic [NREQ*32-1:0] Data = '0;
   logic [NREQ-1:0]   Gnt;
   logic [3:0]        Nibble;
   logic              Blank;
   logic [7:0]        LEDSEL;
   logic              Frame_done;

   int checks = 0;
   int errors = 0;

   // model state: next digit position, owner index (-1 = none), last winner, hold credit, shown frame data
   int          m_pos, m_owner, m_last, m_hold;
   logic [31:0] m_snap;
   logic [7:0]  e_ledsel;
   logic [3:0]  e_nib;
   logic        e_blank, e_fd;

   disp_scheduler #(.NREQ(NREQ), .HOLD_FRAMES(HOLD)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Tick(Tick), .Req(Req), .Data(Data),
      .Gnt(Gnt), .Nibble(Nibble), .Blank(Blank), .LEDSEL(LEDSEL), .Frame_done(Frame_done)
   );

   always #5 Clk = ~Clk;

   function automatic int sig_digits(input logic [31:0] v);
      int n = 1;
      for (int k = 1; k < 8; k++) if ((v >> (4*k)) != 32'd0) n = k + 1;
      return n;
   endfunction

   function automatic logic [NREQ-1:0] exp_gnt();
      return (m_owner < 0) ? '0 : (NREQ'(1) << m_owner);
   endfunction

   function automatic logic [17+NREQ-1:0] obs_vec();
      return {LEDSEL, Nibble, Blank, Gnt, Frame_done};
   endfunction

   function automatic logic [17+NREQ-1:0] exp_vec();
      return {e_ledsel, e_nib, e_blank, exp_gnt(), e_fd};
   endfunction

   task automatic arbitrate();
      bit others = 0;
      bit found = 0;
      int st;
      for (int i = 0; i < NREQ; i++) if (Req[i] && i != m_owner) others = 1;
      if (m_owner >= 0 && Req[m_owner] && (m_hold > 0 || !others)) begin
         m_hold = others ? ((m_hold > 0) ? m_hold - 1 : 0) : HOLD - 1;
      end else if (Req == '0) begin
         m_owner = -1;
      end else begin
         st = (m_owner >= 0) ? m_owner : m_last;
         for (int i = 1; i <= NREQ; i++) begin
            if (!found && Req[(st + i) % NREQ]) begin
               found = 1;
               m_owner = (st + i) % NREQ;
            end
         end
         m_last = m_owner;
         m_hold = HOLD - 1;
      end
      if (m_owner >= 0) m_snap = Data[32*m_owner +: 32];
   endtask

   // one Clk cycle with the given Tick value; model follows the same edge
   task automatic cyc(input bit t);
      Tick = t;
      if (!Rst_n) begin
         m_pos = 0; m_owner = -1; m_last = NREQ - 1; m_hold = 0; m_snap = '0;
         e_ledsel = 8'hFF; e_nib = 4'd0; e_blank = 1'b1; e_fd = 1'b0;
      end else begin
         e_fd = 1'b0;
         if (t) begin
            e_ledsel = 8'hFF ^ (8'd1 << m_pos);
            e_nib    = m_snap[4*m_pos +: 4];
            e_blank  = (m_owner < 0);
`ifdef LEADING_ZERO_BLANK_EN
            if (m_owner >= 0 && m_pos >= sig_digits(m_snap)) e_blank = 1'b1;
`endif
            if (m_pos == 7) begin
               arbitrate();
               e_fd = 1'b1;
            end
            m_pos = (m_pos + 1) % 8;
         end
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Rst_n = 1'b0;
      cyc(1'b0);
      Rst_n = 1'b1;
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cyc(1'b1);
         checks++;
         if ({LEDSEL, Blank, Gnt, Frame_done} !== {8'hFF, 1'b1, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got LEDSEL=%h Blank=%b Gnt=%b Fd=%b want FF 1 0000 0", c, LEDSEL, Blank, Gnt, Frame_done);
         end
      end
      Rst_n = 1'b1;
      cyc(1'b1);
      checks++;
      if ({LEDSEL, Blank} !== {8'hFE, 1'b1}) begin
         errors++;
         $display("FAIL reset_first_tick got LEDSEL=%h Blank=%b want FE 1", LEDSEL, Blank);
      end
   endtask

   task automatic test_single_owner();
      logic [3:0] nibs [8] = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};
      do_reset();
      Req = 4'b0001;
      Data = {$urandom, $urandom, $urandom, 32'h1234ABCD};
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1);
         checks++;
         if (Gnt !== ((k == 7) ? 4'b0001 : 4'b0000) || Frame_done !== (k == 7)) begin
            errors++;
            $display("FAIL single_grant tick=%0d got Gnt=%b Fd=%b want %b %b", k, Gnt, Frame_done, (k == 7) ? 4'b0001 : 4'b0000, k == 7);
         end
      end
      cyc(1'b0);
      checks++;
      if (Frame_done !== 1'b0) begin
         errors++;
         $display("FAIL single_fd_pulse got %b want 0", Frame_done);
      end
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1);
         checks++;
         if ({LEDSEL, Nibble, Blank} !== {~(8'd1 << k), nibs[k], 1'b0}) begin
            errors++;
            $display("FAIL single_digit k=%0d got %h %h %b want %h %h 0", k, LEDSEL, Nibble, Blank, ~(8'd1 << k), nibs[k]);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] gseq [7] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0001};
      do_reset();
      Req = 4'b1011;
      for (int f = 0; f < 7; f++) begin
         Data = {$urandom, $urandom, $urandom, $urandom};
         for (int k = 0; k < 8; k++) begin
            cyc(1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL rr_vec f=%0d k=%0d got %h want %h", f, k, obs_vec(), exp_vec());
            end
         end
         checks++;
         if (Gnt !== gseq[f]) begin
            errors++;
            $display("FAIL rr_seq frame=%0d got %b want %b", f, Gnt, gseq[f]);
         end
      end
   endtask

   task automatic test_release();
      do_reset();
      Req = 4'b0001;
      Data = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 8; k++) cyc(1'b1);
      for (int k = 0; k < 3; k++) cyc(1'b1);
      Req = 4'b0010;
      for (int k = 3; k < 8; k++) begin
         cyc(1'b1);
         checks++;
         if (Gnt !== ((k == 7) ? 4'b0010 : 4'b0001)) begin
            errors++;
            $display("FAIL release_handoff k=%0d got %b want %b", k, Gnt, (k == 7) ? 4'b0010 : 4'b0001);
         end
      end
      for (int k = 0; k < 3; k++) cyc(1'b1);
      Req = 4'b0000;
      for (int k = 3; k < 8; k++) begin
         cyc(1'b1);
         checks++;
         if (Gnt !== ((k == 7) ? 4'b0000 : 4'b0010)) begin
            errors++;
            $display("FAIL release_none k=%0d got %b want %b", k, Gnt, (k == 7) ? 4'b0000 : 4'b0010);
         end
      end
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1);
         checks++;
         if ({Blank, Gnt, LEDSEL} !== {1'b1, 4'b0000, ~(8'd1 << k)}) begin
            errors++;
            $display("FAIL release_blank k=%0d got %b %b %h want 1 0000 %h", k, Blank, Gnt, LEDSEL, ~(8'd1 << k));
         end
      end
   endtask

   task automatic test_snapshot();
      do_reset();
      Req = 4'b0001;
      Data = {$urandom, $urandom, $urandom, 32'h11111111};
      for (int k = 0; k < 8; k++) cyc(1'b1);
      for (int k = 0; k < 4; k++) cyc(1'b1);
      Data[31:0] = 32'h22222222;
      for (int k = 4; k < 8; k++) begin
         cyc(1'b1);
         checks++;
         if (Nibble !== 4'h1) begin
            errors++;
            $display("FAIL snap_frozen k=%0d got %h want 1", k, Nibble);
         end
      end
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1);
         checks++;
         if (Nibble !== 4'h2) begin
            errors++;
            $display("FAIL snap_fresh k=%0d got %h want 2", k, Nibble);
         end
      end
      for (int k = 0; k < 5; k++) cyc(1'b1);
      Rst_n = 1'b0;
      cyc(1'b1);
      checks++;
      if ({LEDSEL, Nibble, Blank, Gnt, Frame_done} !== {8'hFF, 4'h0, 1'b1, 4'b0000, 1'b0}) begin
         errors++;
         $display("FAIL snap_midreset got %h %h %b %b %b want FF 0 1 0000 0", LEDSEL, Nibble, Blank, Gnt, Frame_done);
      end
      Rst_n = 1'b1;
   endtask

   task automatic test_leading_zero();
      logic [31:0] v = 32'h000000A5;
      logic        eb;
      do_reset();
      Req = 4'b0001;
      Data = {$urandom, $urandom, $urandom, v};
      for (int k = 0; k < 8; k++) cyc(1'b1);
      Data[31:0] = 32'h0;
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1);
`ifdef LEADING_ZERO_BLANK_EN
         eb = (k >= 2);
`else
         eb = 1'b0;
`endif
         checks++;
         if ({Nibble, Blank} !== {v[4*k +: 4], eb}) begin
            errors++;
            $display("FAIL lzb_a5 k=%0d got %h %b want %h %b", k, Nibble, Blank, v[4*k +: 4], eb);
         end
      end
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1);
`ifdef LEADING_ZERO_BLANK_EN
         eb = (k != 0);
`else
         eb = 1'b0;
`endif
         checks++;
         if ({Nibble, Blank} !== {4'h0, eb}) begin
            errors++;
            $display("FAIL lzb_zero k=%0d got %h %b want 0 %b", k, Nibble, Blank, eb);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      Req = 4'($urandom);
      Data = {$urandom, $urandom, $urandom, $urandom};
      for (int c = 0; c < 20; c++) begin
         cyc(1'b1);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL b2b_vec c=%0d got %h want %h", c, obs_vec(), exp_vec());
         end
      end
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 15) == 0) Req = 4'($urandom);
         if ($urandom_range(0, 3) == 0) Data[32*$urandom_range(0, NREQ-1) +: 32] = $urandom;
         if ($urandom_range(0, 7) == 0) Data[32*$urandom_range(0, NREQ-1) +: 32] = $urandom & 32'h0000_0FFF;
         Rst_n = ($urandom_range(0, 299) != 0);
         cyc(1'($urandom_range(0, 1)));
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL rand_vec c=%0d got %h want %h", c, obs_vec(), exp_vec());
         end
      end
      Rst_n = 1'b1;
      Tick = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_owner();
      test_round_robin();
      test_release();
      test_snapshot();
      test_leading_zero();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
